pong_match_ctrl: RTL and testbench

//  Match-level sequencer for the Pong demo. Runs the round flow (attract, serve countdown,

---
 rtl/pong_match_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl
//   Match-level sequencer for the Pong demo: attract, serve countdown, play,
//   miss pause and game over. Gates pong_game motion, requests ball serves,
//   keeps a 3-digit BCD score and the lives count for the overlay. All timing
//   is counted in frame_start pulses.
//
//   state | meaning
//   ------+----------------------------------------------
//   IDLE  | attract screen, blinking "PRESS START"
//   SERVE | countdown before the ball is launched
//   PLAY  | ball in motion, hits score, misses cost lives
//   MISS  | pause after a lost ball, then serve again
//   OVER  | no lives left, blinking "GAME OVER"
//
// Ports
//   clk          pixel clock
//   reset        asynchronous active-high reset
//   frame_start  1-cycle pulse per frame
//   btn_start    start button level (synchronised), rising edge used
//   hit_event    1-cycle pulse, ball bounced off paddle
//   miss_event   1-cycle pulse, ball passed paddle
//   game_run     1 only in PLAY
//   ball_serve   1-cycle pulse on the first PLAY cycle
//   score_bcd    {hundreds,tens,ones} BCD score
//   lives        remaining lives
//   game_over    1 only in OVER
//   blink        overlay blink phase
//   state        current state encoding
module pong_match_ctrl #(
   parameter int LIVES_INIT   = 3,
   parameter int SERVE_FRAMES = 60,
   parameter int MISS_FRAMES  = 90,
   parameter int BLINK_FRAMES = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_start,
   input  logic        btn_start,
   input  logic        hit_event,
   input  logic        miss_event,
   output logic        game_run,
   output logic        ball_serve,
   output logic [11:0] score_bcd,
   output logic [1:0]  lives,
   output logic        game_over,
   output logic        blink,
   output logic [2:0]  state
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SERVE = 3'd1;
   localparam logic [2:0] ST_PLAY  = 3'd2;
   localparam logic [2:0] ST_MISS  = 3'd3;
   localparam logic [2:0] ST_OVER  = 3'd4;

   localparam logic [7:0] SERVE_LD  = 8'(SERVE_FRAMES);
   localparam logic [7:0] MISS_LD   = 8'(MISS_FRAMES);
   localparam logic [7:0] BLINK_TC  = 8'(BLINK_FRAMES - 1);
   localparam logic [1:0] LIVES_LD  = 2'(LIVES_INIT);
   localparam logic [11:0] SCORE_MAX = 12'h999;

   logic [2:0]  state_next;
   logic [7:0]  timer;
   logic [7:0]  blink_cnt;
   logic        btn_prev;
   logic        run_ok;
   logic        start_edge;
   logic        timer_done;
   logic        state_change;
   logic        in_attract;
   logic        game_run_d;
   logic        game_over_d;
   logic        ball_serve_d;

   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [3:0] h, t, o;
      h = v[11:8];
      t = v[7:4];
      o = v[3:0];
      if (o < 4'd9) begin
         o = o + 4'd1;
      end else begin
         o = 4'd0;
         if (t < 4'd9) begin
            t = t + 4'd1;
         end else begin
            t = 4'd0;
            h = h + 4'd1;
         end
      end
      return {h, t, o};
   endfunction

   // run_ok masks the first cycle after reset so a button already held
   // through reset release is not mistaken for a press; btn_prev then
   // carries the held level and no edge is ever seen for it.
   assign start_edge   = btn_start & ~btn_prev & run_ok;
   assign timer_done   = frame_start && (timer == 8'd1);
   assign state_change = (state_next != state);
   assign in_attract   = (state == ST_IDLE) || (state == ST_OVER);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         game_run   <= 1'b0;
         game_over  <= 1'b0;
         ball_serve <= 1'b0;
      end else begin
         state      <= state_next;
         game_run   <= game_run_d;
         game_over  <= game_over_d;
         ball_serve <= ball_serve_d;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE, ST_OVER: if (start_edge) state_next = ST_SERVE;
         ST_SERVE:         if (timer_done) state_next = ST_PLAY;
         ST_PLAY:          if (miss_event) state_next = (lives == 2'd1) ? ST_OVER : ST_MISS;
         ST_MISS:          if (timer_done) state_next = ST_SERVE;
         default:          state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      game_run_d   = (state_next == ST_PLAY);
      game_over_d  = (state_next == ST_OVER);
      ball_serve_d = (state == ST_SERVE) && (state_next == ST_PLAY);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_prev <= 1'b0;
         run_ok   <= 1'b0;
      end else begin
         btn_prev <= btn_start;
         run_ok   <= 1'b1;
      end
   end

   // A state change always reloads the timer, so a coincident frame_start
   // is not counted against the new state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer <= 8'd0;
      end else if (state_change) begin
         if (state_next == ST_SERVE)
            timer <= SERVE_LD;
         else if (state_next == ST_MISS)
            timer <= MISS_LD;
      end else if (frame_start && ((state == ST_SERVE) || (state == ST_MISS))) begin
         timer <= timer - 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         score_bcd <= 12'h000;
         lives     <= 2'd0;
      end else if (in_attract && start_edge) begin
         score_bcd <= 12'h000;
         lives     <= LIVES_LD;
      end else if (state == ST_PLAY) begin
         if (miss_event)
            lives <= lives - 2'd1;
         else if (hit_event && (score_bcd != SCORE_MAX))
            score_bcd <= bcd_inc(score_bcd);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink     <= 1'b1;
         blink_cnt <= 8'd0;
      end else if (state_change) begin
         blink     <= 1'b1;
         blink_cnt <= 8'd0;
      end else if (in_attract && frame_start) begin
         if (blink_cnt == BLINK_TC) begin
            blink     <= ~blink;
            blink_cnt <= 8'd0;
         end else begin
            blink_cnt <= blink_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_pong_match_ctrl.sv
module tb_pong_match_ctrl;

   logic        clk;
   logic        reset;
   logic        frame_start;
   logic        btn_start;
   logic        hit_event;
   logic        miss_event;
   logic        game_run;
   logic        ball_serve;
   logic [11:0] score_bcd;
   logic [1:0]  lives;
   logic        game_over;
   logic        blink;
   logic [2:0]  state;

   int n_chk;
   int n_bad;

   pong_match_ctrl #(
      .LIVES_INIT   (3),
      .SERVE_FRAMES (4),
      .MISS_FRAMES  (5),
      .BLINK_FRAMES (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .btn_start   (btn_start),
      .hit_event   (hit_event),
      .miss_event  (miss_event),
      .game_run    (game_run),
      .ball_serve  (ball_serve),
      .score_bcd   (score_bcd),
      .lives       (lives),
      .game_over   (game_over),
      .blink       (blink),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
      end
   endtask

   task automatic hits(input int n);
      for (int i = 0; i < n; i++) begin
         hit_event = 1'b1;
         tick();
         hit_event = 1'b0;
      end
   endtask

   task automatic miss_pulse();
      miss_event = 1'b1;
      tick();
      miss_event = 1'b0;
   endtask

   task automatic press();
      btn_start = 1'b1;
      tick();
      btn_start = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, 12'(state), 12'd0);
      chk({tag, "_score"}, score_bcd, 12'h000);
      chk({tag, "_lives"}, 12'(lives), 12'd0);
      chk({tag, "_run"}, 12'(game_run), 12'd0);
      chk({tag, "_serve"}, 12'(ball_serve), 12'd0);
      chk({tag, "_over"}, 12'(game_over), 12'd0);
      chk({tag, "_blink"}, 12'(blink), 12'd1);
   endtask

   initial begin
      n_chk = 0;
      n_bad = 0;
      reset = 1'b1;
      frame_start = 1'b0;
      btn_start = 1'b0;
      hit_event = 1'b0;
      miss_event = 1'b0;
      #2;
      chk_reset_vals("rst");
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("idle_hold", 12'(state), 12'd0);

      // start a game
      press();
      chk("start_state", 12'(state), 12'd1);
      chk("start_lives", 12'(lives), 12'd3);
      chk("start_score", score_bcd, 12'h000);
      chk("start_run", 12'(game_run), 12'd0);

      // serve countdown: 4 frames
      frames(3);
      chk("serve_3f", 12'(state), 12'd1);
      chk("serve_3f_bs", 12'(ball_serve), 12'd0);
      frames(1);
      chk("play_state", 12'(state), 12'd2);
      chk("play_run", 12'(game_run), 12'd1);
      chk("play_bs", 12'(ball_serve), 12'd1);
      tick();
      chk("play_bs_off", 12'(ball_serve), 12'd0);

      // scoring
      hits(12);
      chk("score_12", score_bcd, 12'h012);
      hits(986);
      chk("score_998", score_bcd, 12'h998);
      hits(1);
      chk("score_999", score_bcd, 12'h999);
      hits(2);
      chk("score_sat", score_bcd, 12'h999);

      // hit + miss together: miss wins
      hit_event = 1'b1;
      miss_event = 1'b1;
      tick();
      hit_event = 1'b0;
      miss_event = 1'b0;
      chk("hm_state", 12'(state), 12'd3);
      chk("hm_lives", 12'(lives), 12'd2);
      chk("hm_score", score_bcd, 12'h999);
      chk("hm_run", 12'(game_run), 12'd0);
      hits(1);
      chk("miss_hit_ign", score_bcd, 12'h999);
      frames(4);
      chk("miss_4f", 12'(state), 12'd3);
      frames(1);
      chk("miss_to_serve", 12'(state), 12'd1);
      press();
      chk("serve_btn_ign", 12'(state), 12'd1);
      chk("serve_btn_lives", 12'(lives), 12'd2);
      frames(4);
      chk("play2_state", 12'(state), 12'd2);

      // miss coincident with frame_start: MISS timer loaded fresh
      frame_start = 1'b1;
      miss_event = 1'b1;
      tick();
      frame_start = 1'b0;
      miss_event = 1'b0;
      chk("miss2_state", 12'(state), 12'd3);
      chk("miss2_lives", 12'(lives), 12'd1);
      frames(4);
      chk("miss2_4f", 12'(state), 12'd3);
      frames(1);
      chk("miss2_serve", 12'(state), 12'd1);
      frames(4);
      chk("play3_state", 12'(state), 12'd2);

      // last life
      miss_pulse();
      chk("over_state", 12'(state), 12'd4);
      chk("over_lives", 12'(lives), 12'd0);
      chk("over_flag", 12'(game_over), 12'd1);
      chk("over_run", 12'(game_run), 12'd0);
      chk("over_blink0", 12'(blink), 12'd1);
      frames(2);
      chk("blink_2f", 12'(blink), 12'd1);
      frames(1);
      chk("blink_3f", 12'(blink), 12'd0);
      frames(2);
      chk("blink_5f", 12'(blink), 12'd0);
      frames(1);
      chk("blink_6f", 12'(blink), 12'd1);
      frames(1);
      hits(1);
      miss_pulse();
      chk("over_ev_ign", 12'(state), 12'd4);
      chk("over_ev_score", score_bcd, 12'h999);

      // restart from OVER
      press();
      chk("rs_state", 12'(state), 12'd1);
      chk("rs_lives", 12'(lives), 12'd3);
      chk("rs_score", score_bcd, 12'h000);
      chk("rs_over", 12'(game_over), 12'd0);
      chk("rs_blink", 12'(blink), 12'd1);
      frames(4);
      chk("rs_play", 12'(state), 12'd2);
      hits(2);
      chk("rs_score2", score_bcd, 12'h002);
      miss_pulse();
      frames(2);
      chk("rs_miss", 12'(state), 12'd3);

      // asynchronous reset mid-countdown, button held through release
      reset = 1'b1;
      btn_start = 1'b1;
      #1;
      chk_reset_vals("arst");
      tick();
      reset = 1'b0;
      tick();
      tick();
      tick();
      chk("held_btn_state", 12'(state), 12'd0);
      chk("held_btn_lives", 12'(lives), 12'd0);
      btn_start = 1'b0;
      tick();
      press();
      chk("post_rst_start", 12'(state), 12'd1);
      chk("post_rst_lives", 12'(lives), 12'd3);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
